// File: rtl/bsg_axi_mem_slave.sv
// AXI4 slave memory model: answers AW/W/B and AR/R bursts from an internal
// word array. Write and read channels use independent state machines so a
// write burst and a read burst can be in flight at the same time.
module bsg_axi_mem_slave #(
    parameter int axi_id_width_p   = 6,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 64,
    parameter int mem_els_p        = 1024
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic [axi_id_width_p-1:0]     axi_awid_i,
    input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
    input  logic [7:0]                    axi_awlen_i,
    input  logic [1:0]                    axi_awburst_i,
    input  logic                          axi_awvalid_i,
    output logic                          axi_awready_o,

    input  logic [axi_data_width_p-1:0]   axi_wdata_i,
    input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
    input  logic                          axi_wlast_i,
    input  logic                          axi_wvalid_i,
    output logic                          axi_wready_o,

    output logic [axi_id_width_p-1:0]     axi_bid_o,
    output logic [1:0]                    axi_bresp_o,
    output logic                          axi_bvalid_o,
    input  logic                          axi_bready_i,

    input  logic [axi_id_width_p-1:0]     axi_arid_i,
    input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
    input  logic [7:0]                    axi_arlen_i,
    input  logic [1:0]                    axi_arburst_i,
    input  logic                          axi_arvalid_i,
    output logic                          axi_arready_o,

    output logic [axi_id_width_p-1:0]     axi_rid_o,
    output logic [axi_data_width_p-1:0]   axi_rdata_o,
    output logic [1:0]                    axi_rresp_o,
    output logic                          axi_rlast_o,
    output logic                          axi_rvalid_o,
    input  logic                          axi_rready_i
);

    localparam int bytes_lp      = axi_data_width_p / 8;
    localparam int byte_shift_lp = $clog2(bytes_lp);
    localparam int idx_width_lp  = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

    localparam logic [1:0] burst_fixed_lp = 2'b00;
    localparam logic [1:0] burst_incr_lp  = 2'b01;
    localparam logic [1:0] resp_okay_lp   = 2'b00;
    localparam logic [1:0] resp_slverr_lp = 2'b10;

    localparam logic [axi_addr_width_p-1:0] mem_els_lp  = axi_addr_width_p'(mem_els_p);
    localparam logic [axi_addr_width_p-1:0] addr_step_lp = axi_addr_width_p'(bytes_lp);

    logic [axi_data_width_p-1:0] mem [mem_els_p];

    // Byte-offset bits are dropped; the full word index is range-checked so
    // wrapped or far addresses never alias onto a real word.
    function automatic logic addr_in_range(input logic [axi_addr_width_p-1:0] addr);
        logic [axi_addr_width_p-1:0] full_idx;
        full_idx = addr >> byte_shift_lp;
        return full_idx < mem_els_lp;
    endfunction

    function automatic logic [idx_width_lp-1:0] word_idx(input logic [axi_addr_width_p-1:0] addr);
        logic [axi_addr_width_p-1:0] full_idx;
        full_idx = addr >> byte_shift_lp;
        return full_idx[idx_width_lp-1:0];
    endfunction

    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == burst_fixed_lp) || (burst == burst_incr_lp);
    endfunction

    // INCR wraps modulo the address width; FIXED and unsupported types hold.
    function automatic logic [axi_addr_width_p-1:0] next_addr(input logic [axi_addr_width_p-1:0] addr,
                                                              input logic [1:0] burst);
        return (burst == burst_incr_lp) ? addr + addr_step_lp : addr;
    endfunction

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    w_state_e                    w_state_reg, w_state_next;
    logic [axi_id_width_p-1:0]   w_id_reg;
    logic [axi_addr_width_p-1:0] w_addr_reg;
    logic [7:0]                  w_len_reg;
    logic [1:0]                  w_burst_reg;
    logic [7:0]                  w_cnt_reg;
    logic                        w_err_reg;

    logic                        aw_hs, w_hs;
    logic                        w_final_beat, w_beat_ok, w_beat_err, mem_we;
    logic [axi_data_width_p-1:0] w_mask;

    assign aw_hs        = axi_awvalid_i && axi_awready_o;
    assign w_hs         = axi_wvalid_i && axi_wready_o;
    assign w_final_beat = (w_cnt_reg == w_len_reg);
    assign w_beat_ok    = burst_ok(w_burst_reg) && addr_in_range(w_addr_reg);
    // The beat count governs termination; a misplaced or missing wlast only flags an error.
    assign w_beat_err   = !w_beat_ok || (axi_wlast_i != w_final_beat);
    assign mem_we       = w_hs && w_beat_ok;

    assign axi_bid_o    = w_id_reg;
    assign axi_bresp_o  = w_err_reg ? resp_slverr_lp : resp_okay_lp;

    genvar gi;
    generate
        for (gi = 0; gi < bytes_lp; gi++) begin : g_wmask
            assign w_mask[gi*8 +: 8] = {8{axi_wstrb_i[gi]}};
        end
    endgenerate

    // Write FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) w_state_reg <= W_IDLE;
        else            w_state_reg <= w_state_next;
    end

    // Write FSM next state and handshake outputs; ready is held low during reset
    always_comb begin
        w_state_next  = w_state_reg;
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                axi_awready_o = reset_n_i;
                if (axi_awvalid_i && reset_n_i) w_state_next = W_DATA;
            end
            W_DATA: begin
                axi_wready_o = 1'b1;
                if (axi_wvalid_i && w_final_beat) w_state_next = W_RESP;
            end
            W_RESP: begin
                axi_bvalid_o = 1'b1;
                if (axi_bready_i) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write burst context: latched on AW, advanced per accepted beat
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_id_reg    <= '0;
            w_addr_reg  <= '0;
            w_len_reg   <= '0;
            w_burst_reg <= '0;
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
        end else if (aw_hs) begin
            w_id_reg    <= axi_awid_i;
            w_addr_reg  <= axi_awaddr_i;
            w_len_reg   <= axi_awlen_i;
            w_burst_reg <= axi_awburst_i;
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
        end else if (w_hs) begin
            w_cnt_reg  <= w_cnt_reg + 8'd1;
            w_addr_reg <= next_addr(w_addr_reg, w_burst_reg);
            if (w_beat_err) w_err_reg <= 1'b1;
        end
    end

    // Memory array write with byte enables; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[word_idx(w_addr_reg)] <= (mem[word_idx(w_addr_reg)] & ~w_mask)
                                       | (axi_wdata_i & w_mask);
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    r_state_e                    r_state_reg, r_state_next;
    logic [axi_id_width_p-1:0]   r_id_reg;
    logic [axi_addr_width_p-1:0] r_addr_reg;
    logic [7:0]                  r_len_reg;
    logic [1:0]                  r_burst_reg;
    logic [7:0]                  r_cnt_reg;
    logic [axi_data_width_p-1:0] r_data_reg;
    logic [1:0]                  r_resp_reg;
    logic                        r_last_reg;

    logic                        ar_hs, r_hs;
    logic [axi_addr_width_p-1:0] r_load_addr;
    logic [1:0]                  r_load_burst;
    logic                        r_load_ok, r_load_last;
    logic [axi_data_width_p-1:0] r_load_data;

    assign ar_hs = axi_arvalid_i && axi_arready_o;
    assign r_hs  = axi_rvalid_o && axi_rready_i;

    assign axi_rid_o   = r_id_reg;
    assign axi_rdata_o = r_data_reg;
    assign axi_rresp_o = r_resp_reg;
    assign axi_rlast_o = r_last_reg && axi_rvalid_o;

    // Read FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state_reg <= R_IDLE;
        else            r_state_reg <= r_state_next;
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        r_state_next  = r_state_reg;
        axi_arready_o = 1'b0;
        axi_rvalid_o  = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                axi_arready_o = reset_n_i;
                if (axi_arvalid_i && reset_n_i) r_state_next = R_DATA;
            end
            R_DATA: begin
                axi_rvalid_o = 1'b1;
                if (axi_rready_i && r_last_reg) r_state_next = R_IDLE;
            end
        endcase
    end

    // Beat to load next: the first beat on AR, otherwise the one after the current beat
    always_comb begin
        r_load_addr  = ar_hs ? axi_araddr_i  : next_addr(r_addr_reg, r_burst_reg);
        r_load_burst = ar_hs ? axi_arburst_i : r_burst_reg;
        r_load_last  = ar_hs ? (axi_arlen_i == 8'd0) : ((r_cnt_reg + 8'd1) == r_len_reg);
        r_load_ok    = burst_ok(r_load_burst) && addr_in_range(r_load_addr);
        r_load_data  = '0;
        if (r_load_ok) r_load_data = mem[word_idx(r_load_addr)];
    end

    // Registered read beat: memory is sampled at the load edge, so a write in
    // the same cycle shows up only on a later beat
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_id_reg    <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_burst_reg <= '0;
            r_cnt_reg   <= '0;
            r_data_reg  <= '0;
            r_resp_reg  <= '0;
            r_last_reg  <= 1'b0;
        end else if (ar_hs) begin
            r_id_reg    <= axi_arid_i;
            r_addr_reg  <= axi_araddr_i;
            r_len_reg   <= axi_arlen_i;
            r_burst_reg <= axi_arburst_i;
            r_cnt_reg   <= '0;
            r_data_reg  <= r_load_data;
            r_resp_reg  <= r_load_ok ? resp_okay_lp : resp_slverr_lp;
            r_last_reg  <= r_load_last;
        end else if (r_hs && !r_last_reg) begin
            r_addr_reg  <= r_load_addr;
            r_cnt_reg   <= r_cnt_reg + 8'd1;
            r_data_reg  <= r_load_data;
            r_resp_reg  <= r_load_ok ? resp_okay_lp : resp_slverr_lp;
            r_last_reg  <= r_load_last;
        end
    end

endmodule

// File: tb/tb_bsg_axi_mem_slave.sv
// Directed bench for bsg_axi_mem_slave: write/read bursts, byte strobes,
// error responses, read stall, concurrency and mid-burst reset.
module tb_bsg_axi_mem_slave;

    logic        clk;
    logic        reset_n;
    logic [5:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [5:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [5:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    // write driver stimulus / observations
    logic [63:0] wbeat_data [16];
    logic [7:0]  wbeat_strb [16];
    logic        obs_bvalid_beat [16];
    logic [5:0]  obs_bid;
    logic [1:0]  obs_bresp;
    logic        obs_bvalid_done, obs_awready_done;

    // read driver observations
    logic [63:0] obs_rdata [16];
    logic [1:0]  obs_rresp [16];
    logic        obs_rlast [16];
    logic [5:0]  obs_rid   [16];
    logic        obs_rvalid_first, obs_rvalid_end;
    logic [63:0] st_rdata [5];
    logic [1:0]  st_rresp [5];
    logic        st_rlast [5];
    logic        st_rvalid[5];
    logic [5:0]  st_rid   [5];

    bsg_axi_mem_slave #(
        .axi_id_width_p  (6),
        .axi_addr_width_p(32),
        .axi_data_width_p(64),
        .mem_els_p       (1024)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
        .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
        .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int last_beat);
        int n;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin step(); n++; end
        if (n >= 100) begin checks++; errors++; $display("FAIL aw_timeout: awready=%0b required 1", awready); end
        step();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbeat_data[b]; wstrb = wbeat_strb[b]; wlast = (b == last_beat); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin step(); n++; end
            if (n >= 100) begin checks++; errors++; $display("FAIL w_timeout: wready=%0b required 1", wready); end
            step();
            obs_bvalid_beat[b] = bvalid;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 100) begin step(); n++; end
        if (n >= 100) begin checks++; errors++; $display("FAIL b_timeout: bvalid=%0b required 1", bvalid); end
        obs_bid = bid; obs_bresp = bresp;
        bready = 1'b1;
        step();
        bready = 1'b0;
        obs_bvalid_done = bvalid; obs_awready_done = awready;
        $display("write id=%0d addr=0x%08h len=%0d burst=%0d -> bid=%0d bresp=%0d", id, addr, len, burst, obs_bid, obs_bresp);
    endtask

    task automatic read_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input int stall_beat);
        int n;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin step(); n++; end
        if (n >= 100) begin checks++; errors++; $display("FAIL ar_timeout: arready=%0b required 1", arready); end
        step();
        arvalid = 1'b0;
        obs_rvalid_first = rvalid;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < 100) begin step(); n++; end
            if (n >= 100) begin checks++; errors++; $display("FAIL r_timeout: rvalid=%0b required 1", rvalid); end
            obs_rdata[b] = rdata; obs_rresp[b] = rresp; obs_rlast[b] = rlast; obs_rid[b] = rid;
            if (b == stall_beat) begin
                rready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    st_rvalid[s] = rvalid; st_rdata[s] = rdata; st_rresp[s] = rresp;
                    st_rlast[s] = rlast; st_rid[s] = rid;
                end
            end
            rready = 1'b1;
            step();
            rready = 1'b0;
        end
        obs_rvalid_end = rvalid;
        $display("read id=%0d addr=0x%08h len=%0d burst=%0d -> beat0 rdata=0x%016h rresp=%0d", id, addr, len, burst, obs_rdata[0], obs_rresp[0]);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b00000) begin
            errors++; $display("FAIL reset_handshake: got %05b required 00000", {awready, arready, wready, bvalid, rvalid});
        end
        checks++;
        if ({rdata, rresp, rlast, bresp} !== 69'd0) begin
            errors++; $display("FAIL reset_data: rdata=0x%016h rresp=%0d rlast=%0b bresp=%0d required all 0", rdata, rresp, rlast, bresp);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
            errors++; $display("FAIL reset_release: got %05b required 11000", {awready, arready, wready, bvalid, rvalid});
        end
        $display("reset released: awready=%0b arready=%0b", awready, arready);
    endtask

    task automatic test_incr_burst();
        logic [63:0] exp_d [4];
        exp_d[0] = 64'h1111_1111_1111_1111; exp_d[1] = 64'h2222_2222_2222_2222;
        exp_d[2] = 64'h3333_3333_3333_3333; exp_d[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) begin wbeat_data[i] = exp_d[i]; wbeat_strb[i] = 8'hFF; end
        write_burst(6'd5, 32'h40, 8'd3, 2'b01, 3);
        checks++;
        if ({obs_bvalid_beat[2], obs_bvalid_beat[3]} !== 2'b01) begin
            errors++; $display("FAIL incr_b_timing: bvalid beat2/beat3=%02b required 01", {obs_bvalid_beat[2], obs_bvalid_beat[3]});
        end
        checks++;
        if (obs_bid !== 6'd5 || obs_bresp !== 2'b00) begin
            errors++; $display("FAIL incr_bresp: bid=%0d bresp=%0d required 5 0", obs_bid, obs_bresp);
        end
        checks++;
        if (obs_bvalid_done !== 1'b0 || obs_awready_done !== 1'b1) begin
            errors++; $display("FAIL incr_b_done: bvalid=%0b awready=%0b required 0 1", obs_bvalid_done, obs_awready_done);
        end
        read_burst(6'd7, 32'h40, 8'd3, 2'b01, -1);
        checks++;
        if (obs_rvalid_first !== 1'b1) begin
            errors++; $display("FAIL incr_r_latency: rvalid=%0b required 1", obs_rvalid_first);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_rdata[i] !== exp_d[i] || obs_rresp[i] !== 2'b00 || obs_rlast[i] !== (i == 3) || obs_rid[i] !== 6'd7) begin
                errors++;
                $display("FAIL incr_rbeat%0d: rdata=0x%016h rresp=%0d rlast=%0b rid=%0d required 0x%016h 0 %0b 7",
                         i, obs_rdata[i], obs_rresp[i], obs_rlast[i], obs_rid[i], exp_d[i], (i == 3));
            end
        end
        checks++;
        if (obs_rvalid_end !== 1'b0) begin
            errors++; $display("FAIL incr_r_end: rvalid=%0b required 0", obs_rvalid_end);
        end
    endtask

    task automatic test_strobe();
        wbeat_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbeat_strb[0] = 8'hFF;
        write_burst(6'd1, 32'h80, 8'd0, 2'b01, 0);
        wbeat_data[0] = 64'h0; wbeat_strb[0] = 8'h0F;
        write_burst(6'd1, 32'h80, 8'd0, 2'b01, 0);
        read_burst(6'd1, 32'h80, 8'd0, 2'b01, -1);
        checks++;
        if (obs_rdata[0] !== 64'hFFFF_FFFF_0000_0000 || obs_rresp[0] !== 2'b00 || obs_rlast[0] !== 1'b1) begin
            errors++; $display("FAIL strobe_read: rdata=0x%016h rresp=%0d rlast=%0b required 0xffffffff00000000 0 1",
                               obs_rdata[0], obs_rresp[0], obs_rlast[0]);
        end
    endtask

    task automatic test_write_errors();
        wbeat_data[0] = 64'hA5A5_A5A5_A5A5_A5A5; wbeat_strb[0] = 8'hFF;
        wbeat_data[1] = 64'h5A5A_5A5A_5A5A_5A5A; wbeat_strb[1] = 8'hFF;
        write_burst(6'd9, 32'h100, 8'd1, 2'b01, 0);
        checks++;
        if ({obs_bvalid_beat[0], obs_bvalid_beat[1]} !== 2'b01) begin
            errors++; $display("FAIL early_wlast_beats: bvalid beat0/beat1=%02b required 01", {obs_bvalid_beat[0], obs_bvalid_beat[1]});
        end
        checks++;
        if (obs_bresp !== 2'b10 || obs_bid !== 6'd9) begin
            errors++; $display("FAIL early_wlast_bresp: bresp=%0d bid=%0d required 2 9", obs_bresp, obs_bid);
        end
        wbeat_data[0] = 64'hDEAD_BEEF_DEAD_BEEF; wbeat_strb[0] = 8'hFF;
        write_burst(6'd2, 32'h40, 8'd0, 2'b10, 0);
        checks++;
        if (obs_bresp !== 2'b10) begin
            errors++; $display("FAIL wrap_bresp: bresp=%0d required 2", obs_bresp);
        end
        read_burst(6'd2, 32'h40, 8'd0, 2'b01, -1);
        checks++;
        if (obs_rdata[0] !== 64'h1111_1111_1111_1111 || obs_rresp[0] !== 2'b00) begin
            errors++; $display("FAIL wrap_mem_unchanged: rdata=0x%016h rresp=%0d required 0x1111111111111111 0", obs_rdata[0], obs_rresp[0]);
        end
    endtask

    task automatic test_out_of_range();
        wbeat_data[0] = 64'h0123_4567_89AB_CDEF; wbeat_strb[0] = 8'hFF;
        write_burst(6'd3, 32'h1FF8, 8'd0, 2'b01, 0);
        read_burst(6'd9, 32'h1FF8, 8'd1, 2'b01, 0);
        checks++;
        if (obs_rdata[0] !== 64'h0123_4567_89AB_CDEF || obs_rresp[0] !== 2'b00 || obs_rlast[0] !== 1'b0) begin
            errors++; $display("FAIL oor_beat0: rdata=0x%016h rresp=%0d rlast=%0b required 0x0123456789abcdef 0 0",
                               obs_rdata[0], obs_rresp[0], obs_rlast[0]);
        end
        checks++;
        if (obs_rdata[1] !== 64'h0 || obs_rresp[1] !== 2'b10 || obs_rlast[1] !== 1'b1) begin
            errors++; $display("FAIL oor_beat1: rdata=0x%016h rresp=%0d rlast=%0b required 0 2 1",
                               obs_rdata[1], obs_rresp[1], obs_rlast[1]);
        end
        for (int s = 0; s < 5; s++) begin
            checks++;
            if ({st_rvalid[s], st_rlast[s]} !== 2'b10 || st_rdata[s] !== 64'h0123_4567_89AB_CDEF ||
                st_rresp[s] !== 2'b00 || st_rid[s] !== 6'd9) begin
                errors++; $display("FAIL stall_hold%0d: rvalid=%0b rlast=%0b rdata=0x%016h rresp=%0d rid=%0d required 1 0 0x0123456789abcdef 0 9",
                                   s, st_rvalid[s], st_rlast[s], st_rdata[s], st_rresp[s], st_rid[s]);
            end
        end
    endtask

    task automatic test_concurrent();
        wbeat_data[0] = 64'hAAAA_AAAA_AAAA_AAAA; wbeat_strb[0] = 8'hFF;
        write_burst(6'd1, 32'h300, 8'd0, 2'b01, 0);
        awid = 6'd3; awaddr = 32'h300; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        arid = 6'd4; araddr = 32'h300; arlen = 8'd2; arburst = 2'b00; arvalid = 1'b1;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if ({awready, wready, arready, rvalid} !== 4'b0101 || rdata !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            errors++; $display("FAIL conc_accept: aw/w/ar/rvalid=%04b rdata=0x%016h required 0101 0xaaaaaaaaaaaaaaaa",
                               {awready, wready, arready, rvalid}, rdata);
        end
        wdata = 64'h5555_5555_5555_5555; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
        step();
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        checks++;
        if (bvalid !== 1'b1 || rdata !== 64'hAAAA_AAAA_AAAA_AAAA || rlast !== 1'b0) begin
            errors++; $display("FAIL conc_same_cycle: bvalid=%0b rdata=0x%016h rlast=%0b required 1 0xaaaaaaaaaaaaaaaa 0", bvalid, rdata, rlast);
        end
        step();
        bready = 1'b0;
        checks++;
        if (rdata !== 64'h5555_5555_5555_5555 || rlast !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL conc_next_beat: rdata=0x%016h rlast=%0b bvalid=%0b required 0x5555555555555555 1 0", rdata, rlast, bvalid);
        end
        step();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL conc_done: rvalid=%0b arready=%0b required 0 1", rvalid, arready);
        end
        $display("concurrent write/read at 0x300 done");
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] exp_d [4];
        int n;
        exp_d[0] = 64'hA0A0_A0A0_A0A0_A0A0; exp_d[1] = 64'hA1A1_A1A1_A1A1_A1A1;
        exp_d[2] = 64'hA2A2_A2A2_A2A2_A2A2; exp_d[3] = 64'hA3A3_A3A3_A3A3_A3A3;
        for (int i = 0; i < 4; i++) begin wbeat_data[i] = exp_d[i]; wbeat_strb[i] = 8'hFF; end
        write_burst(6'd6, 32'h200, 8'd3, 2'b01, 3);
        arid = 6'd2; araddr = 32'h200; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin step(); n++; end
        step();
        arvalid = 1'b0; rready = 1'b1;
        step();
        step();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_d[2]) begin
            errors++; $display("FAIL midrst_beat2: rvalid=%0b rdata=0x%016h required 1 0x%016h", rvalid, rdata, exp_d[2]);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0 || rdata !== 64'h0) begin
            errors++; $display("FAIL midrst_async: rvalid=%0b arready=%0b rdata=0x%016h required 0 0 0", rvalid, arready, rdata);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        checks++;
        if ({awready, arready, rvalid, bvalid} !== 4'b1100) begin
            errors++; $display("FAIL midrst_release: aw/ar/rvalid/bvalid=%04b required 1100", {awready, arready, rvalid, bvalid});
        end
        read_burst(6'd8, 32'h200, 8'd3, 2'b01, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_rdata[i] !== exp_d[i] || obs_rresp[i] !== 2'b00 || obs_rlast[i] !== (i == 3) || obs_rid[i] !== 6'd8) begin
                errors++; $display("FAIL midrst_reread%0d: rdata=0x%016h rresp=%0d rlast=%0b rid=%0d required 0x%016h 0 %0b 8",
                                   i, obs_rdata[i], obs_rresp[i], obs_rlast[i], obs_rid[i], exp_d[i], (i == 3));
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_incr_burst();
        test_strobe();
        test_write_errors();
        test_out_of_range();
        test_concurrent();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_axi_mem_slave.md
Name:
bsg_axi_mem_slave

Overview:
Single-clock AXI4 slave memory model that sits directly downstream of the DMC emulator's AXI master port and answers its AW/W/B and AR/R traffic from an internal word array. Write and read channels have independent state machines, so the DMC emulator loop can close in simulation or on FPGA without a vendor memory controller.

Parameters:
axi_id_width_p, 6, width of awid/bid/arid/rid
axi_addr_width_p, 32, byte address width
axi_data_width_p, 64, beat width in bits (power of 2, >=16); bytes_lp = axi_data_width_p/8
mem_els_p, 1024, number of axi_data_width_p-bit words; word index = addr >> log2(bytes_lp)

Ports:
clk_i  in  1  single clock for all logic
reset_n_i  in  1  asynchronous active-low reset
axi_awid_i  in  axi_id_width_p  write burst id
axi_awaddr_i  in  axi_addr_width_p  write start byte address
axi_awlen_i  in  8  beats-1
axi_awburst_i  in  2  00 FIXED, 01 INCR, others unsupported
axi_awvalid_i  in  1  AW valid
axi_awready_o  out  1  AW ready
axi_wdata_i  in  axi_data_width_p  write beat data
axi_wstrb_i  in  axi_data_width_p/8  byte enables
axi_wlast_i  in  1  master's last-beat flag
axi_wvalid_i  in  1  W valid
axi_wready_o  out  1  W ready
axi_bid_o  out  axi_id_width_p  echoed awid
axi_bresp_o  out  2  00 OKAY, 10 SLVERR
axi_bvalid_o  out  1  B valid
axi_bready_i  in  1  B ready
axi_arid_i  in  axi_id_width_p  read burst id
axi_araddr_i  in  axi_addr_width_p  read start byte address
axi_arlen_i  in  8  beats-1
axi_arburst_i  in  2  same encoding as awburst
axi_arvalid_i  in  1  AR valid
axi_arready_o  out  1  AR ready
axi_rid_o  out  axi_id_width_p  echoed arid
axi_rdata_o  out  axi_data_width_p  read beat data (registered)
axi_rresp_o  out  2  00 OKAY, 10 SLVERR
axi_rlast_o  out  1  final beat flag
axi_rvalid_o  out  1  R valid
axi_rready_i  in  1  R ready

Behaviour:
- Reset (async, reset_n_i=0): all outputs 0 immediately. The write FSM enters W_IDLE and the read FSM enters R_IDLE. Memory contents are not reset. After reset deasserts, awready_o=1 and arready_o=1 on the next edge-free cycle.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready_o=1, wready_o=0. An AW handshake latches id, addr, len, burst; clears the beat counter and the error flag.
  - W_DATA: awready_o=0, wready_o=1. On each W handshake, byte i of mem[word] is written if wstrb[i]=1.
  - INCR adds bytes_lp to addr per beat. FIXED holds addr. Unsupported burst types write nothing and set the error flag.
- Write beat count, out-of-range and error handling:
  - Exactly len+1 beats are accepted; this count governs, not wlast.
  - If wlast_i is seen on a beat other than beat len, or is missing on beat len, the error flag is set.
  - A beat with word index >= mem_els_p is dropped and sets the error flag; other beats of that burst still write.
- W_RESP: entered the cycle after the final beat. bvalid_o=1, bid_o=latched id, bresp_o=10 if the error flag is set, else 00. It holds until bready_i, then returns to W_IDLE, where awready_o=1 the next cycle. No overlapping write bursts.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready_o=1. An AR handshake latches id, addr, len, burst.
  - Latency: rvalid_o=1 in the cycle after the AR handshake, with rdata_o loaded from mem at that time.
  - On each R handshake the next beat is loaded into rdata_o and rvalid_o stays 1 (back-to-back beats).
  - rlast_o=1 only on beat len. The rlast handshake returns the FSM to R_IDLE.
  - While rready_i=0, rid/rdata/rresp/rlast are held stable.
- Read errors: a beat that is out of range or uses an unsupported burst type returns rdata_o=0 and rresp_o=10; other beats return 00. rresp is per beat.
- Channel concurrency: the write and read channels run concurrently.
  - A read beat captures memory at its load edge, so a same-cycle write to that word is not visible; the following beat sees it.
  - A write and a read issued together are both accepted in the same cycle.
- Address width rule: addr increments wrap modulo 2^axi_addr_width_p; the wrapped index is range-checked normally. Byte-offset bits below bytes_lp are ignored (aligned access).
- Reset mid-burst: any in-flight burst is abandoned and no B/R response is issued. Memory keeps any beats already written.

Test Plan:
- Reset then release -> awready_o=1, arready_o=1, wready_o=0, bvalid_o=0, rvalid_o=0.
- AW id=5, addr=0x40, len=3, INCR; W beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with wstrb=0xFF and wlast on beat 3 -> bvalid_o one cycle after beat 3, bid_o=5, bresp_o=00. Then AR id=7, addr=0x40, len=3 -> rvalid_o the cycle after the AR handshake, the same four words in order, rlast_o only on beat 3, rid_o=7, rresp_o=00.
- Write 0xFFFF_FFFF_FFFF_FFFF to 0x80, then 0x0 with wstrb=0x0F -> a read of 0x80 returns 0xFFFF_FFFF_0000_0000.
- AW len=1 with wlast on beat 0 -> two beats are accepted and bresp_o=10. awburst=10 (WRAP) -> bresp_o=10 and memory is unchanged.
- AR at mem_els_p*8-8, len=1 -> beat 0 returns stored data with rresp 00; beat 1 returns rdata 0 with rresp 10. rready_i held 0 for 5 cycles -> outputs held stable.
- Pull reset_n_i low during a read burst's beat 2 -> rvalid_o=0 immediately; after release arready_o=1 and the next burst completes normally.
